multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the multicycle MIPS datapath: PC/IR update, register file, ALU operand muxes, immediate extender and unified memory.
- Sits beside the datapath and receives the opcode from the instruction register and the ALU zero flag.
- Drives the mux selects and write enables, including the sign/zero-extend select of the immediate extender.
- Stalls on a memory-ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH
- op  input  6  opcode field of instruction register (IR[31:26])
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes current access this cycle
- iord  output  1  memory address select: 0 PC, 1 ALUOut
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register load
- regdst  output  1  write register: 0 rt, 1 rd
- memtoreg  output  1  writeback data: 0 ALUOut, 1 memory data
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0 PC, 1 reg A
- alusrcb  output  2  ALU B: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- aluop  output  3  000 add, 001 sub, 010 funct decode, 011 and, 100 or
- imm_zext  output  1  extender mode: 0 sign-extend, 1 zero-extend
- pcsrc  output  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target
- pc_en  output  1  PC load = pcwrite or (branch and zero)
- illegal_op  output  1  one-cycle pulse in DECODE on unknown opcode
- state  output  4  current state encoding, for debug

Behaviour:
- State register updates on posedge clk. Asynchronous reset sets state to FETCH (0).
- While reset is high, every output is 0 except state, which reads 0.
- All outputs not listed for a state are 0. alusrcb, aluop and pcsrc default to 00/000/00.
- States (encoding) and outputs:
  - FETCH(0): alusrcb=01; irwrite and pcwrite only in a cycle with mem_ready=1. Holds until mem_ready, then goes to DECODE.
  - DECODE(1): alusrcb=11 (branch target precompute). Next state by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 001100 -> ANDIEX; 001101 -> ORIEX; 000010 -> JEX; any other -> FETCH with illegal_op=1.
  - MEMADR(2): alusrca=1, alusrcb=10. Goes to MEMRD if op=100011, else MEMWR.
  - MEMRD(3): iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB(4): memtoreg=1, regwrite=1. Then FETCH.
  - MEMWR(5): iord=1, memwrite=1. memwrite stays asserted while stalled. Goes to FETCH on mem_ready.
  - RTYPEEX(6): alusrca=1, aluop=010. Then RTYPEWB.
  - RTYPEWB(7): regdst=1, regwrite=1. Then FETCH.
  - BEQEX(8): alusrca=1, aluop=001, pcsrc=01, branch=1. Then FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10. Then IWB.
  - ANDIEX(10): alusrca=1, alusrcb=10, aluop=011, imm_zext=1. Then IWB.
  - ORIEX(11): alusrca=1, alusrcb=10, aluop=100, imm_zext=1. Then IWB.
  - IWB(12): regwrite=1. Then FETCH.
  - JEX(13): pcsrc=10, pcwrite=1. Then FETCH.
  - Encodings 14–15 are unreachable; if ever entered, next state is FETCH with all outputs 0.
- Latencies with no stalls: lw 5 cycles; sw 4; R-type 4; addi/andi/ori 4; beq 3; j 3; illegal 2.
- Each memory stall cycle adds 1 cycle. Outputs are stable throughout a stall.
- pc_en is combinational from state, mem_ready and zero. The same-cycle zero value is used in BEQEX.
- op is sampled in DECODE and MEMADR only. The IR must not change outside FETCH, which is guaranteed because irwrite is asserted only in FETCH.
- With MEM_HANDSHAKE=0, FETCH/MEMRD/MEMWR each last exactly 1 cycle.
- Reset asserted mid-instruction: state and outputs drop immediately and asynchronously. On release, FETCH begins on the next clock edge.
- No write enable is asserted in the cycle in which reset deasserts, unless that cycle is FETCH with mem_ready=1.

Test Plan:
- Reset held 3 cycles, release with mem_ready=1, op=000000: state sequence 0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. pc_en=1 only in state 0.
- op=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD: sequence 0,0,0,1,2,3,3,3,3,4,0. irwrite asserted exactly once. memtoreg=regwrite=1 in state 4.
- op=000100: zero=1 in BEQEX gives pc_en=1 with pcsrc=01; repeat with zero=0, giving pc_en=0. Both runs return to FETCH after 3 cycles.
- op=001100 (andi) then op=001000 (addi): imm_zext=1 with aluop=011 in ANDIEX; imm_zext=0 with aluop=000 in ADDIEX. Both reach IWB with regwrite=1.
- op=101011, mem_ready=0 for 2 cycles in MEMWR: memwrite=1 and iord=1 for 3 consecutive cycles, then FETCH. Separately, op=111111 gives illegal_op=1 in DECODE only, next state 0.
- Assert reset asynchronously mid-MEMWR: memwrite falls before the next clk edge and state=0. After release the FETCH sequence resumes normally.

Source files
------------

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Moore control FSM for a multicycle MIPS datapath. It sequences PC/IR
//   update, register file, ALU operand muxes, the immediate extender and the
//   unified memory. Memory states can stall on a mem_ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, forces FETCH
//   op[5:0]    in   opcode field of the instruction register
//   zero       in   ALU zero flag, used for beq in BEQEX
//   mem_ready  in   memory completes the current access this cycle
//   iord       out  memory address select (0 PC, 1 ALUOut)
//   memwrite   out  memory write enable
//   irwrite    out  instruction register load
//   regdst     out  write register select (0 rt, 1 rd)
//   memtoreg   out  writeback data select (0 ALUOut, 1 memory data)
//   regwrite   out  register file write enable
//   alusrca    out  ALU A select (0 PC, 1 reg A)
//   alusrcb    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop      out  000 add, 001 sub, 010 funct, 011 and, 100 or
//   imm_zext   out  immediate extender mode (0 sign, 1 zero)
//   pcsrc      out  next PC select (00 ALU, 01 ALUOut, 10 jump)
//   pc_en      out  PC load = pcwrite | (branch & zero)
//   illegal_op out  pulse in DECODE on an unknown opcode
//   state      out  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic       imm_zext,
  output logic [1:0] pcsrc,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ANDIEX  = 4'd10,
    S_ORIEX   = 4'd11,
    S_IWB     = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  state_t r_state;
  logic   w_ready;
  logic   w_pcwrite;
  logic   w_branch;

  // Without the handshake every memory access completes in one cycle.
  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state   = r_state;

  // State register with inline next-state decode; op is only consulted in
  // DECODE and MEMADR. Encodings 14-15 fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (w_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_ANDI:      r_state <= S_ANDIEX;
            OP_ORI:       r_state <= S_ORIEX;
            OP_J:         r_state <= S_JEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (w_ready) r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   if (w_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_ADDIEX:  r_state <= S_IWB;
        S_ANDIEX:  r_state <= S_IWB;
        S_ORIEX:   r_state <= S_IWB;
        S_IWB:     r_state <= S_FETCH;
        S_JEX:     r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the registered state. Everything is forced low while
  // reset is high so outputs drop asynchronously with the state.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 3'b000;
    imm_zext   = 1'b0;
    pcsrc      = 2'b00;
    illegal_op = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          alusrcb   = 2'b01;
          // PC and IR only load in the cycle the fetch actually completes.
          irwrite   = w_ready;
          w_pcwrite = w_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: illegal_op = 1'b0;
            default:                        illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = 3'b010;
        end
        S_RTYPEWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca  = 1'b1;
          aluop    = 3'b001;
          pcsrc    = 2'b01;
          w_branch = 1'b1;
        end
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_ANDIEX: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          aluop    = 3'b011;
          imm_zext = 1'b1;
        end
        S_ORIEX: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          aluop    = 3'b100;
          imm_zext = 1'b1;
        end
        S_IWB: regwrite = 1'b1;
        S_JEX: begin
          pcsrc     = 2'b10;
          w_pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = w_pcwrite | (w_branch & zero);
  end

endmodule
